// File: rtl/block_transpose_buffer.sv
// rtl/block_transpose_buffer.sv - N x N block ring buffer with per-block transposed readout
// Optional framing checker and sticky err built when BLOCK_TRANSPOSE_BUFFER_ERR_EN is defined.
module block_transpose_buffer #(
  parameter int W_IO  = 16,
  parameter int N     = 8,
  parameter int NBANK = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*W_IO-1:0]          in_data,
  input  logic                       in_sob,
  input  logic                       in_eob,
  input  logic                       in_sof,
  input  logic                       in_trps,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*W_IO-1:0]          out_data,
  output logic                       out_sob,
  output logic                       out_eob,
  output logic                       out_sof,
  output logic [$clog2(NBANK+1)-1:0] full_cnt,
  output logic                       err
);

  localparam int RW = $clog2(N);
  localparam int BW = $clog2(NBANK);
  localparam int CW = $clog2(NBANK + 1);

  logic [N*W_IO-1:0] mem [NBANK][N];
  logic [NBANK-1:0]  trps_flag;
  logic [NBANK-1:0]  sof_flag;

  logic [BW-1:0] wr_bank, rd_bank;
  logic [RW-1:0] wr_row, rd_row;

  logic wr_fire, rd_fire, wr_last, rd_last, commit, release_bank;

  assign in_ready     = (full_cnt != CW'(NBANK));
  assign out_valid    = (full_cnt != '0);
  assign wr_fire      = in_valid & in_ready;
  assign rd_fire      = out_valid & out_ready;
  assign wr_last      = (wr_row == RW'(N - 1));
  assign rd_last      = (rd_row == RW'(N - 1));
  assign commit       = wr_fire & wr_last;
  assign release_bank = rd_fire & rd_last;

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_row] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trps_flag <= '0;
      sof_flag  <= '0;
    end else if (wr_fire && wr_row == '0) begin
      trps_flag[wr_bank] <= in_trps;
      sof_flag[wr_bank]  <= in_sof;
    end
  end

  // Bank indices wrap naturally because NBANK is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_row  <= '0;
      wr_bank <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_row  <= '0;
        wr_bank <= wr_bank + BW'(1);
      end else begin
        wr_row <= wr_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_row  <= '0;
      rd_bank <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_row  <= '0;
        rd_bank <= rd_bank + BW'(1);
      end else begin
        rd_row <= rd_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_cnt <= '0;
    end else if (commit && !release_bank) begin
      full_cnt <= full_cnt + CW'(1);
    end else if (!commit && release_bank) begin
      full_cnt <= full_cnt - CW'(1);
    end
  end

  // Transposed readout gathers column rd_row across all stored rows.
  always_comb begin
    out_data = mem[rd_bank][rd_row];
    if (trps_flag[rd_bank]) begin
      for (int c = 0; c < N; c++) begin
        out_data[c*W_IO +: W_IO] = mem[rd_bank][c][int'(rd_row)*W_IO +: W_IO];
      end
    end
  end

  assign out_sob = out_valid & (rd_row == '0);
  assign out_eob = out_valid & rd_last;
  assign out_sof = out_valid & (rd_row == '0) & sof_flag[rd_bank];

`ifdef BLOCK_TRANSPOSE_BUFFER_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_fire && ((in_sob != (wr_row == '0)) || (in_eob != wr_last))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_framing;
  assign unused_framing = in_sob ^ in_eob;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_block_transpose_buffer.sv
// tb/tb_block_transpose_buffer.sv - scoreboard bench for block_transpose_buffer
module tb_block_transpose_buffer;

  localparam int W_IO  = 16;
  localparam int N     = 8;
  localparam int NBANK = 2;
  localparam int DW    = N * W_IO;
  localparam int CW    = $clog2(NBANK + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sob = 1'b0;
  logic          in_eob = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_trps = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sob, out_eob, out_sof;
  logic [CW-1:0] full_cnt;
  logic          err;

  typedef struct {
    logic [DW-1:0] d;
    logic          sob;
    logic          eob;
    logic          sof;
  } row_t;

  row_t sb[$];
  row_t exp_row;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_out = 0;
  logic exp_err;

  block_transpose_buffer #(.W_IO(W_IO), .N(N), .NBANK(NBANK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof), .in_trps(in_trps),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
    .full_cnt(full_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W_IO-1:0] elem(input int tag, input int r, input int c);
    return {8'(tag), 4'(r), 4'(c)};
  endfunction

  function automatic logic [DW-1:0] in_row(input int tag, input int r);
    logic [DW-1:0] d;
    for (int c = 0; c < N; c++) d[c*W_IO +: W_IO] = elem(tag, r, c);
    return d;
  endfunction

  // Output scoreboard: one pop per accepted output row.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 1, 0);
      end else begin
        exp_row = sb.pop_front();
        check("out_data", out_data, exp_row.d);
        check("out_sob", out_sob, exp_row.sob);
        check("out_eob", out_eob, exp_row.eob);
        check("out_sof", out_sof, exp_row.sof);
        last_out = cyc + 1;
      end
    end
  end

  task automatic send_row(input logic [DW-1:0] d, input logic sob, input logic eob,
                          input logic sof, input logic trps);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sob = sob; in_eob = eob; in_sof = sof; in_trps = trps;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_block(input int tag, input logic trps, input logic sof, input int bad_eob_row);
    row_t e;
    for (int r = 0; r < N; r++)
      send_row(in_row(tag, r), r == 0, (r == N - 1) || (r == bad_eob_row), sof, trps);
    in_valid = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++)
        e.d[c*W_IO +: W_IO] = trps ? elem(tag, c, r) : elem(tag, r, c);
      e.sob = (r == 0);
      e.eob = (r == N - 1);
      e.sof = sof && (r == 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", (sb.size() == 0) && !out_valid, 1);
  endtask

  initial begin
    int t0;
`ifdef BLOCK_TRANSPOSE_BUFFER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_full_cnt", full_cnt, 0);
    check("rst_out_sob", out_sob, 0);
    check("rst_out_eob", out_eob, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_err", err, 0);

    // 1: plain block, streaming out
    out_ready = 1'b1;
    send_block(0, 1'b0, 1'b0, -1);
    check("t1_out_valid_rise", out_valid, 1);
    check("t1_full_cnt_1", full_cnt, 1);
    wait_drain();
    check("t1_full_cnt_0", full_cnt, 0);

    // 2: transposed, start of frame
    send_block(0, 1'b1, 1'b1, -1);
    wait_drain();

    // 3: backpressure, third block stalls until space frees
    out_ready = 1'b0;
    send_block(1, 1'b0, 1'b0, -1);
    send_block(2, 1'b1, 1'b0, -1);
    check("t3_full_cnt_2", full_cnt, 2);
    @(negedge clk);
    check("t3_stall_data_a", out_data, sb[0].d);
    check("t3_stall_sob_a", out_sob, 1);
    repeat (2) @(negedge clk);
    check("t3_stall_data_b", out_data, sb[0].d);
    in_valid = 1'b1; in_data = in_row(3, 0); in_sob = 1'b1; in_eob = 1'b0;
    @(negedge clk);
    check("t3_in_ready_0", in_ready, 0);
    @(posedge clk);
    #1;
    check("t3_full_cnt_hold", full_cnt, 2);
    out_ready = 1'b1;
    send_block(3, 1'b0, 1'b1, -1);
    wait_drain();

    // 4: back-to-back blocks, alternating transpose
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      send_block(16 + k, 1'(k % 2), 1'b0, -1);
      check("t4_full_cnt", full_cnt, 1);
    end
    check("t4_input_cycles", last_acc - t0, 64);
    wait_drain();
    check("t4_last_out_cycle", last_out - last_acc, 8);

    // 5: misplaced eob on row 5
    check("t5_err_before", err, 0);
    send_block(5, 1'b0, 1'b0, 5);
    check("t5_err_set", err, exp_err);
    wait_drain();
    send_block(6, 1'b1, 1'b0, -1);
    wait_drain();
    check("t5_err_sticky", err, exp_err);

    // 6: reset with one pending block and a partial block
    out_ready = 1'b0;
    send_block(7, 1'b0, 1'b0, -1);
    for (int r = 0; r < 4; r++) send_row(in_row(8, r), r == 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_full_cnt", full_cnt, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_err_cleared", err, 0);
    sb.delete();
    out_ready = 1'b1;
    send_block(9, 1'b1, 1'b1, -1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
